// File: rtl/emu_seq_pkg.sv
// Shared types for the co-emulation step sequencer.
// Holds the sequencer state set and the tester byte width.
package emu_seq_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_LOAD,
    S_CLK_HI,
    S_CLK_LO,
    S_GET,
    S_RD,
    S_RDW,
    S_RES
  } state_t;
endpackage

// File: rtl/emu_step_sequencer_if.sv
// Captured-result stream between sequencer and host.
// Master drives data/index/valid, slave drives ready.
interface emu_step_sequencer_if #(
  parameter int ADDR_W = 3
);
  import emu_seq_pkg::*;

  logic [BYTE_W-1:0] res_data;
  logic [ADDR_W-1:0] res_idx;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output res_data,
    output res_idx,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_idx,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/emu_clk_pulse.sv
// One controlled DUT clock period per start strobe.
// fall marks the last high cycle, fin the last low cycle.
module emu_clk_pulse #(
  parameter int CLK_HALF = 2
) (
  input  logic clk_emu,
  input  logic nreset,
  input  logic start,
  output logic clk_dut,
  output logic fall,
  output logic fin
);
  localparam int CW = $clog2(CLK_HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_HALF - 1);

  logic [CW-1:0] cnt;
  logic          run;

  assign fall = run & clk_dut & (cnt == LAST);
  assign fin  = run & ~clk_dut & (cnt == LAST);

  // high phase, then low phase, CLK_HALF cycles each
  always_ff @(posedge clk_emu or negedge nreset) begin
    if (!nreset) begin
      run     <= 1'b0;
      clk_dut <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      run     <= 1'b1;
      clk_dut <= 1'b1;
      cnt     <= '0;
    end else if (run) begin
      if (cnt == LAST) begin
        cnt <= '0;
        if (clk_dut) clk_dut <= 1'b0;
        else         run     <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/emu_step_sequencer.sv
// Per-step write/load/clock/get/read sequencer for the tester.
// Stimulus bytes come from a host-written register file.
module emu_step_sequencer
  import emu_seq_pkg::*;
#(
  parameter int NUM_STIM = 1,
  parameter int NUM_OUT  = 1,
  parameter int ADDR_W   = 3,
  parameter int CLK_HALF = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk_emu,
  input  logic              nreset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [BYTE_W-1:0] cfg_data,
  input  logic              go,
  input  logic [CNT_W-1:0]  step_cnt,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  emu_step_sequencer_if.master res,
  output logic [BYTE_W-1:0] Din_emu,
  output logic [ADDR_W-1:0] Addr_emu,
  output logic              load_emu,
  output logic              get_emu,
  output logic              clk_dut,
  input  logic [BYTE_W-1:0] Dout_emu
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_S = ADDR_W'(NUM_STIM - 1);
  localparam logic [ADDR_W-1:0] LAST_O = ADDR_W'(NUM_OUT - 1);

  state_t             state;
  logic [BYTE_W-1:0]  stim_reg [DEPTH];
  logic [ADDR_W-1:0]  i, j, i_nx, j_nx;
  logic [CNT_W-1:0]   remaining, rem_nx;
  logic               stop_lat;
  logic               start, fall, fin;

  assign i_nx   = i + 1'b1;
  assign j_nx   = j + 1'b1;
  assign rem_nx = remaining - 1'b1;
  assign start  = (state == S_LOAD);

  emu_clk_pulse #(
    .CLK_HALF (CLK_HALF)
  ) u_pulse (
    .clk_emu (clk_emu),
    .nreset  (nreset),
    .start   (start),
    .clk_dut (clk_dut),
    .fall    (fall),
    .fin     (fin)
  );

  // host stimulus writes, frozen for the whole run
  always_ff @(posedge clk_emu or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < DEPTH; k++) stim_reg[k] <= '0;
    end else if (cfg_we && !busy) begin
      stim_reg[cfg_addr] <= cfg_data;
    end
  end

  // step sequencer with registered tester and host outputs
  always_ff @(posedge clk_emu or negedge nreset) begin
    if (!nreset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      load_emu      <= 1'b0;
      get_emu       <= 1'b0;
      Din_emu       <= '0;
      Addr_emu      <= '0;
      res.res_data  <= '0;
      res.res_idx   <= '0;
      res.res_valid <= 1'b0;
      i             <= '0;
      j             <= '0;
      remaining     <= '0;
      stop_lat      <= 1'b0;
    end else begin
      load_emu <= 1'b0;
      get_emu  <= 1'b0;
      done     <= 1'b0;
      if (busy && stop) stop_lat <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            if (step_cnt == '0) begin
              done <= 1'b1;
            end else begin
              remaining <= step_cnt;
              busy      <= 1'b1;
              stop_lat  <= 1'b0;
              i         <= '0;
              Addr_emu  <= '0;
              Din_emu   <= stim_reg[0];
              state     <= S_WR;
            end
          end
        end
        S_WR: begin
          if (i == LAST_S) begin
            load_emu <= 1'b1;
            state    <= S_LOAD;
          end else begin
            i        <= i_nx;
            Addr_emu <= i_nx;
            Din_emu  <= stim_reg[i_nx];
          end
        end
        S_LOAD: state <= S_CLK_HI;
        S_CLK_HI: if (fall) state <= S_CLK_LO;
        S_CLK_LO: begin
          if (fin) begin
            get_emu <= 1'b1;
            state   <= S_GET;
          end
        end
        S_GET: begin
          j        <= '0;
          Addr_emu <= '0;
          state    <= S_RD;
        end
        S_RD: state <= S_RDW;
        S_RDW: begin
          res.res_data  <= Dout_emu;
          res.res_idx   <= j;
          res.res_valid <= 1'b1;
          state         <= S_RES;
        end
        S_RES: begin
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            if (j != LAST_O) begin
              j        <= j_nx;
              Addr_emu <= j_nx;
              state    <= S_RD;
            end else begin
              remaining <= rem_nx;
              if (rem_nx == '0 || stop_lat || stop) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                i        <= '0;
                Addr_emu <= '0;
                Din_emu  <= stim_reg[0];
                state    <= S_WR;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_emu_step_sequencer.sv
// Bench for emu_step_sequencer: two configurations, tester model,
// cycle tables, corner sequences and randomized runs.
module tb_emu_step_sequencer;
  import emu_seq_pkg::*;

  typedef struct packed {
    logic [2:0] addr;
    logic       ld;
    logic       gt;
    logic       ck;
    logic       vl;
    logic [2:0] idx;
    logic       bsy;
    logic       dn;
    logic [7:0] din;
  } vec_t;

  logic clk_emu = 1'b0;
  always #5 clk_emu = ~clk_emu;

  logic        nreset;
  logic        cfg_we [2];
  logic [2:0]  cfg_addr [2];
  logic [7:0]  cfg_data [2];
  logic        go [2];
  logic [15:0] step_cnt [2];
  logic        stop [2];
  logic        res_ready [2];
  logic        busy [2], done [2];
  logic        load [2], get [2], clkd [2];
  logic [7:0]  din [2], dout [2];
  logic [2:0]  addr [2];
  logic        rvalid [2];
  logic [7:0]  rdata [2];
  logic [2:0]  ridx [2];

  emu_step_sequencer_if #(.ADDR_W(3)) rif0 ();
  emu_step_sequencer_if #(.ADDR_W(3)) rif1 ();

  assign rif0.res_ready = res_ready[0];
  assign rif1.res_ready = res_ready[1];
  assign rvalid[0] = rif0.res_valid;
  assign rvalid[1] = rif1.res_valid;
  assign rdata[0]  = rif0.res_data;
  assign rdata[1]  = rif1.res_data;
  assign ridx[0]   = rif0.res_idx;
  assign ridx[1]   = rif1.res_idx;

  emu_step_sequencer #(
    .NUM_STIM(1), .NUM_OUT(1), .ADDR_W(3), .CLK_HALF(2), .CNT_W(16)
  ) dut_a (
    .clk_emu(clk_emu), .nreset(nreset),
    .cfg_we(cfg_we[0]), .cfg_addr(cfg_addr[0]), .cfg_data(cfg_data[0]),
    .go(go[0]), .step_cnt(step_cnt[0]), .stop(stop[0]),
    .busy(busy[0]), .done(done[0]), .res(rif0),
    .Din_emu(din[0]), .Addr_emu(addr[0]), .load_emu(load[0]),
    .get_emu(get[0]), .clk_dut(clkd[0]), .Dout_emu(dout[0])
  );

  emu_step_sequencer #(
    .NUM_STIM(2), .NUM_OUT(3), .ADDR_W(3), .CLK_HALF(2), .CNT_W(16)
  ) dut_b (
    .clk_emu(clk_emu), .nreset(nreset),
    .cfg_we(cfg_we[1]), .cfg_addr(cfg_addr[1]), .cfg_data(cfg_data[1]),
    .go(go[1]), .step_cnt(step_cnt[1]), .stop(stop[1]),
    .busy(busy[1]), .done(done[1]), .res(rif1),
    .Din_emu(din[1]), .Addr_emu(addr[1]), .load_emu(load[1]),
    .get_emu(get[1]), .clk_dut(clkd[1]), .Dout_emu(dout[1])
  );

  function automatic int ns(input int g);
    return (g == 0) ? 1 : 2;
  endfunction

  function automatic int no(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // tester + DUT model: each clk_dut rise adds (sum of loaded stim)+1
  logic [7:0] stim_in [2][8];
  logic [7:0] ds [2], lsum [2], tseed [2];
  logic       tsync [2];
  logic       pclk [2], pval [2], prdy [2];
  logic [10:0] pres [2];
  logic [10:0] rq [2][$];
  int rises [2] = '{0, 0};
  int loads [2] = '{0, 0};
  int gets  [2] = '{0, 0};
  int vio   [2] = '{0, 0};

  always @(posedge clk_emu) begin
    logic [7:0] s;
    for (int g = 0; g < 2; g++) begin
      s = 8'd0;
      for (int k = 0; k < ns(g); k++) s = s + stim_in[g][k];
      if (load[g]) lsum[g] <= s;
      if (!load[g] && !get[g]) begin
        stim_in[g][addr[g]] <= din[g];
        dout[g] <= ds[g] + 8'(addr[g]);
      end
      if (tsync[g]) ds[g] <= tseed[g];
      else if (clkd[g] && !pclk[g]) ds[g] <= ds[g] + lsum[g] + 8'd1;
      if (clkd[g] && !pclk[g]) rises[g]++;
      if (load[g]) loads[g]++;
      if (get[g]) gets[g]++;
      if (rvalid[g] && clkd[g]) vio[g]++;
      if (rvalid[g] && get[g]) vio[g]++;
      if (rvalid[g] && pval[g] && !prdy[g] && {ridx[g], rdata[g]} != pres[g])
        vio[g]++;
      if (rvalid[g] && res_ready[g]) rq[g].push_back({ridx[g], rdata[g]});
      pclk[g] <= clkd[g];
      pval[g] <= rvalid[g];
      prdy[g] <= res_ready[g];
      pres[g] <= {ridx[g], rdata[g]};
    end
  end

  int total = 0;
  int bad = 0;
  logic [7:0] sh [2][8];
  logic [7:0] seedv [2];
  int r0 [2], l0 [2], g0 [2], v0 [2];
  vec_t ta [$];
  vec_t tb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int ld, input int gt,
                              input int ck, input int vl, input int ix,
                              input int bs, input int dn, input int dd);
    vec_t r;
    r.addr = 3'(a); r.ld = 1'(ld); r.gt = 1'(gt); r.ck = 1'(ck);
    r.vl = 1'(vl); r.idx = 3'(ix); r.bsy = 1'(bs); r.dn = 1'(dn);
    r.din = 8'(dd);
    return r;
  endfunction

  task automatic cfg(input int g, input int a, input logic [7:0] d);
    cfg_we[g] = 1'b1; cfg_addr[g] = 3'(a); cfg_data[g] = d;
    @(negedge clk_emu);
    cfg_we[g] = 1'b0;
    sh[g][a] = d;
  endtask

  task automatic start(input int g, input int n, input logic [7:0] seed);
    rq[g].delete();
    r0[g] = rises[g]; l0[g] = loads[g]; g0[g] = gets[g]; v0[g] = vio[g];
    tseed[g] = seed; seedv[g] = seed; tsync[g] = 1'b1;
    go[g] = 1'b1; step_cnt[g] = 16'(n);
    @(negedge clk_emu);
    go[g] = 1'b0; tsync[g] = 1'b0;
  endtask

  task automatic finish(input int g, input int pct, input int lim);
    int c = 0;
    while (!done[g] && c < lim) begin
      res_ready[g] = ($urandom_range(99) < pct);
      @(negedge clk_emu);
      c++;
    end
    chk($sformatf("done%0d", g), done[g], 1);
    chk($sformatf("idle%0d", g), busy[g], 0);
    res_ready[g] = 1'b1;
  endtask

  task automatic check_run(input int g, input int steps);
    int s = 0;
    int e;
    int m = steps * no(g);
    for (int k = 0; k < ns(g); k++) s += sh[g][k];
    chk($sformatf("nres%0d", g), rq[g].size(), m);
    for (int k = 0; k < rq[g].size() && k < m; k++) begin
      e = (seedv[g] + (k / no(g) + 1) * (s + 1) + k % no(g)) & 255;
      chk($sformatf("res%0d_%0d", g, k), rq[g][k], {3'(k % no(g)), 8'(e)});
    end
    chk($sformatf("rises%0d", g), rises[g] - r0[g], steps);
    chk($sformatf("loads%0d", g), loads[g] - l0[g], steps);
    chk($sformatf("gets%0d", g), gets[g] - g0[g], steps);
    chk($sformatf("vio%0d", g), vio[g] - v0[g], 0);
  endtask

  task automatic run_table(input int g, input vec_t t [$]);
    for (int i = 0; i < t.size(); i++) begin
      chk($sformatf("vec%0d_%0d", g, i),
          {addr[g], load[g], get[g], clkd[g], rvalid[g], ridx[g],
           busy[g], done[g], din[g]}, t[i]);
      @(negedge clk_emu);
    end
  endtask

  initial begin
    int c;
    int g;
    int n;
    logic [7:0] hd;
    int hg;
    ta.push_back(mk(0,0,0,0,0,0,1,0,8'h08));
    ta.push_back(mk(0,1,0,0,0,0,1,0,8'h08));
    ta.push_back(mk(0,0,0,1,0,0,1,0,8'h08));
    ta.push_back(mk(0,0,0,1,0,0,1,0,8'h08));
    ta.push_back(mk(0,0,0,0,0,0,1,0,8'h08));
    ta.push_back(mk(0,0,0,0,0,0,1,0,8'h08));
    ta.push_back(mk(0,0,1,0,0,0,1,0,8'h08));
    ta.push_back(mk(0,0,0,0,0,0,1,0,8'h08));
    ta.push_back(mk(0,0,0,0,0,0,1,0,8'h08));
    ta.push_back(mk(0,0,0,0,1,0,1,0,8'h08));
    ta.push_back(mk(0,0,0,0,0,0,0,1,8'h08));
    tb.push_back(mk(0,0,0,0,0,0,1,0,8'h31));
    tb.push_back(mk(1,0,0,0,0,0,1,0,8'h42));
    tb.push_back(mk(1,1,0,0,0,0,1,0,8'h42));
    tb.push_back(mk(1,0,0,1,0,0,1,0,8'h42));
    tb.push_back(mk(1,0,0,1,0,0,1,0,8'h42));
    tb.push_back(mk(1,0,0,0,0,0,1,0,8'h42));
    tb.push_back(mk(1,0,0,0,0,0,1,0,8'h42));
    tb.push_back(mk(1,0,1,0,0,0,1,0,8'h42));
    tb.push_back(mk(0,0,0,0,0,0,1,0,8'h42));
    tb.push_back(mk(0,0,0,0,0,0,1,0,8'h42));
    tb.push_back(mk(0,0,0,0,1,0,1,0,8'h42));
    tb.push_back(mk(1,0,0,0,0,0,1,0,8'h42));
    tb.push_back(mk(1,0,0,0,0,0,1,0,8'h42));
    tb.push_back(mk(1,0,0,0,1,1,1,0,8'h42));
    tb.push_back(mk(2,0,0,0,0,1,1,0,8'h42));
    tb.push_back(mk(2,0,0,0,0,1,1,0,8'h42));
    tb.push_back(mk(2,0,0,0,1,2,1,0,8'h42));
    tb.push_back(mk(2,0,0,0,0,2,0,1,8'h42));

    nreset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cfg_we[k] = 0; cfg_addr[k] = 0; cfg_data[k] = 0; go[k] = 0;
      step_cnt[k] = 0; stop[k] = 0; res_ready[k] = 1; tsync[k] = 0;
      tseed[k] = 0;
      for (int a = 0; a < 8; a++) sh[k][a] = 8'h00;
    end
    repeat (3) @(negedge clk_emu);
    for (int k = 0; k < 2; k++)
      chk($sformatf("rst%0d", k),
          {busy[k], done[k], load[k], get[k], clkd[k], rvalid[k],
           addr[k], din[k], rdata[k], ridx[k]}, 0);
    nreset = 1'b1;
    @(negedge clk_emu);

    // single step, cycle exact
    cfg(0, 0, 8'h08);
    start(0, 1, 8'hFC);
    run_table(0, ta);
    check_run(0, 1);
    chk("single_res", 32'(rq[0].size() > 0 ? rq[0][0][7:0] : 8'hXX), 8'h05);

    // two stim bytes, three outputs, cycle exact
    cfg(1, 0, 8'h31);
    cfg(1, 1, 8'h42);
    start(1, 1, 8'h10);
    run_table(1, tb);
    check_run(1, 1);

    // step_cnt of zero
    start(1, 0, 8'h00);
    chk("zero_done", {done[1], busy[1]}, 2'b10);
    @(negedge clk_emu);
    check_run(1, 0);

    // multi-step count
    cfg(0, 0, 8'h04);
    start(0, 3, 8'h20);
    finish(0, 100, 200);
    check_run(0, 3);

    // backpressure
    res_ready[0] = 1'b0;
    start(0, 2, 8'h55);
    c = 0;
    while (!rvalid[0] && c < 100) begin
      @(negedge clk_emu);
      c++;
    end
    chk("bp_valid", rvalid[0], 1);
    hd = rdata[0];
    hg = gets[0];
    repeat (20) @(negedge clk_emu);
    chk("bp_hold", {rvalid[0], clkd[0], rdata[0]}, {1'b1, 1'b0, hd});
    chk("bp_gets", gets[0] - hg, 0);
    finish(0, 100, 200);
    check_run(0, 2);

    // stop during second step, cfg write ignored
    start(0, 100, 8'h77);
    c = 0;
    while (!((rises[0] - r0[0]) >= 2 && !clkd[0]) && c < 200) begin
      @(negedge clk_emu);
      c++;
    end
    chk("stop_wait", (rises[0] - r0[0]) == 2 && !clkd[0], 1);
    stop[0] = 1'b1;
    cfg_we[0] = 1'b1; cfg_addr[0] = 3'd0; cfg_data[0] = 8'hFF;
    @(negedge clk_emu);
    stop[0] = 1'b0;
    cfg_we[0] = 1'b0;
    finish(0, 100, 400);
    check_run(0, 2);
    start(0, 1, 8'h01);
    finish(0, 100, 200);
    check_run(0, 1);

    // randomized runs
    for (int it = 0; it < 10; it++) begin
      g = $urandom_range(1, 0);
      for (int a = 0; a < ns(g); a++) cfg(g, a, 8'($urandom));
      n = $urandom_range(4, 1);
      start(g, n, 8'($urandom));
      finish(g, $urandom_range(100, 40), 400 * n + 100);
      check_run(g, n);
    end

    // asynchronous reset mid CLK_HI
    start(0, 5, 8'h33);
    c = 0;
    while (!clkd[0] && c < 50) begin
      @(negedge clk_emu);
      c++;
    end
    chk("hi_wait", clkd[0], 1);
    #2 nreset = 1'b0;
    #1 chk("arst", {clkd[0], load[0], get[0], busy[0], rvalid[0]}, 0);
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 8; a++) sh[k][a] = 8'h00;
    @(negedge clk_emu);
    nreset = 1'b1;
    @(negedge clk_emu);
    start(0, 1, 8'h90);
    chk("rst_stim", {busy[0], din[0]}, {1'b1, 8'h00});
    finish(0, 100, 200);
    check_run(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/emu_step_sequencer.md
Name: emu_step_sequencer

Overview:
Automatic transaction sequencer for the poorman's co-emulation chip-test wrapper. It replaces host bit-banging of Din_emu/Addr_emu/load_emu/get_emu/clk_dut with a fixed per-cycle sequence: write stimulus bytes, load, pulse clk_dut, capture, then read back output bytes. Host side is a small stimulus register file plus a go/count command. Captured bytes stream out over a valid/ready port. The block sits between the host interface (MCU/UART bridge) and the *_tester wrapper, in the clk_emu domain.

Parameters:
NUM_STIM, 1, number of stimulus bytes written per step (addresses 0..NUM_STIM-1)
NUM_OUT, 1, number of output bytes read back per step (addresses 0..NUM_OUT-1)
ADDR_W, 3, width of Addr_emu and cfg_addr; NUM_STIM and NUM_OUT must each be <= 2**ADDR_W
CLK_HALF, 2, clk_emu cycles per clk_dut high phase and per low phase (>=1)
CNT_W, 16, width of the step count

Ports:
clk_emu  in  1  emulation clock; all logic on posedge
nreset  in  1  asynchronous active-low reset
cfg_we  in  1  write stim_reg[cfg_addr] <= cfg_data; ignored while busy
cfg_addr  in  ADDR_W  stimulus register index
cfg_data  in  8  stimulus byte
go  in  1  start run of step_cnt steps; sampled only in IDLE
step_cnt  in  CNT_W  number of DUT clock steps to run
stop  in  1  finish the current step, then return to IDLE
busy  out  1  high from go acceptance until return to IDLE
done  out  1  one-cycle pulse on return to IDLE
res_data  out  8  captured output byte
res_idx  out  ADDR_W  output address of res_data
res_valid  out  1  res_data valid; held until res_ready
res_ready  in  1  host accepts result
Din_emu  out  8  to tester
Addr_emu  out  ADDR_W  to tester
load_emu  out  1  to tester
get_emu  out  1  to tester
clk_dut  out  1  controlled DUT clock to tester
Dout_emu  in  8  from tester

Behaviour:
- Reset (async, nreset=0): state IDLE; every output 0; stim_reg cleared to 0x00; counters 0.
- Tester semantics: load_emu and get_emu are mutually exclusive one-cycle pulses. When both are low, the tester writes stimIn[Addr_emu]<=Din_emu and registers Dout_emu<=vectOut[Addr_emu].
- IDLE: go=1 with step_cnt=0 produces a done pulse next cycle and no tester activity. go=1 with step_cnt>0 latches remaining=step_cnt, sets busy, and goes to WR with i=0.
- WR: drive Addr_emu=i and Din_emu=stim_reg[i] for one cycle each, i=0..NUM_STIM-1; then LOAD.
- LOAD: load_emu=1 for one cycle; Addr_emu and Din_emu held.
- CLK_HI: clk_dut=1 for CLK_HALF cycles.
- CLK_LO: clk_dut=0 for CLK_HALF cycles.
- GET: get_emu=1 for one cycle.
- RD: drive Addr_emu=j for one cycle, then RDW for one cycle. Dout_emu is valid in RDW and is registered into res_data, with res_idx=j and res_valid=1.
- RES: stall until res_ready=1. Then either j++ and back to RD, or, after NUM_OUT-1, remaining-- and the next step.
- Next step: if remaining==0 or a stop was latched, go to IDLE with done=1 and busy=0; otherwise go to WR.
- Backpressure freezes the sequence with clk_dut low. The DUT sees no extra edges.
- stop is latched at any time while busy and acted on only at the step boundary. It never truncates clk_dut pulses or drops results.
- cfg_we while busy is ignored; stim_reg stays constant for the whole run.
- Reset mid-run aborts immediately. clk_dut drops to 0 asynchronously, and any partial result is discarded.
- Per-step latency (no backpressure) = NUM_STIM + 1 + 2*CLK_HALF + 1 + 2*NUM_OUT + NUM_OUT(RES) cycles.
- remaining is a CNT_W down-counter with no wrap; step_cnt = all-ones runs 2**CNT_W-1 steps.

Decomposition:
- Package emu_seq_pkg: state enum (IDLE, WR, LOAD, CLK_HI, CLK_LO, GET, RD, RDW, RES) and the Din/Dout byte-width constant 8.
- One sub-module, emu_clk_pulse: generates the CLK_HALF high/low clk_dut pulse on a start strobe and returns a finished strobe.
- Stim register file and FSM stay in the top level.

Test Plan:
- Reset: assert nreset=0 mid-CLK_HI → clk_dut, load_emu, get_emu, busy and res_valid all 0 immediately; stim_reg reads back 0x00.
- Single step: cfg stim[0]=0x08 (pong reset=1), go with step_cnt=1, res_ready tied 1, tester model returning 0x05 → one WR with Din=0x08, one load pulse, clk_dut high 2 then low 2, one get pulse, res_data=0x05 idx=0, done pulse, total 10 cycles from go.
- Multi-step count: step_cnt=3 with stim 0x04 (enable) → exactly 3 clk_dut rising edges and 3 results, then done.
- Backpressure: res_ready held 0 for 20 cycles → res_valid and res_data stable, clk_dut stays 0, no extra get_emu.
- Stop: step_cnt=100, stop pulsed during the 2nd step's CLK_LO → exactly 2 results, done after the 2nd; cfg_we during the run is ignored.
- NUM_STIM=2, NUM_OUT=3: Addr_emu sequence 0,1 (WR) then 0,1,2 (RD); res_idx 0,1,2; go with step_cnt=0 → done next cycle, no load_emu.
